byte_packer: RTL

//  Downstream of the 8-bit skid buffer. Packs BEATS consecutive valid/ready bytes into one wide word.

---
 rtl/byte_packer_pkg.sv | 18 +
 rtl/byte_packer_out_reg.sv | 77 +++++++
 rtl/byte_packer.sv | 104 ++++++++++
 3 files changed

// File: rtl/byte_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer_pkg
// Brief   : Shared types and default sizing for the byte packer.
// Revision: 1.0
// ============================================================================
package byte_packer_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_BEATS  = 4;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage : byte_packer_pkg
`default_nettype wire

// File: rtl/byte_packer_out_reg.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer_out_reg
// Brief   : Registered output word with valid/ready handoff. Lane mask port
//           present only when BYTE_PACKER_FLUSH_EN is defined.
// Revision: 1.0
// ============================================================================
module byte_packer_out_reg
    import byte_packer_pkg::*;
#(
`ifdef BYTE_PACKER_FLUSH_EN
    parameter int LANES  = DEFAULT_BEATS,
`endif
    parameter int WORD_W = DEFAULT_DATA_W * DEFAULT_BEATS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_data,
`ifdef BYTE_PACKER_FLUSH_EN
    input  logic [LANES-1:0]  i_load_keep,
    output logic [LANES-1:0]  o_keep,
`endif
    input  logic              i_handoff_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data
);

    out_state_t        r_state;
    out_state_t        w_state_nxt;
    logic [WORD_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load in the handoff cycle replaces the word and keeps the state full.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OUT_EMPTY: if (i_load) w_state_nxt = OUT_FULL;
            OUT_FULL:  if (i_handoff_ready && !i_load) w_state_nxt = OUT_EMPTY;
            default:   w_state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end
    end

`ifdef BYTE_PACKER_FLUSH_EN
    logic [LANES-1:0] r_keep;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_keep <= '0;
        end else if (i_load) begin
            r_keep <= i_load_keep;
        end
    end

    assign o_keep = r_keep;
`endif

    assign o_valid = (r_state == OUT_FULL);
    assign o_data  = r_data;

endmodule : byte_packer_out_reg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Brief   : Packs BEATS narrow beats into one wide registered word, little-
//           endian lanes. BYTE_PACKER_FLUSH_EN adds i_last_i / e_keep_o.
// Revision: 1.0
// ============================================================================
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int BEATS  = DEFAULT_BEATS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid_i,
    input  logic [DATA_W-1:0]       i_data_i,
    output logic                    i_ready_o,
`ifdef BYTE_PACKER_FLUSH_EN
    input  logic                    i_last_i,
    output logic [BEATS-1:0]        e_keep_o,
`endif
    input  logic                    e_ready_i,
    output logic                    e_valid_o,
    output logic [BEATS*DATA_W-1:0] e_data_o
);

    localparam int                 WORD_W = BEATS * DATA_W;
    localparam int                 CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0]   c_last = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] w_word;
    logic              w_final;
    logic              w_accept;
    logic              w_load;

`ifdef BYTE_PACKER_FLUSH_EN
    logic [BEATS-1:0]  w_keep;

    assign w_final = (r_cnt == c_last) | (i_valid_i & i_last_i);

    always_comb begin
        w_keep = '0;
        for (int k = 0; k < BEATS; k++) begin
            w_keep[k] = (CNT_W'(k) <= r_cnt);
        end
    end
`else
    assign w_final = (r_cnt == c_last);
`endif

    // Only a word-closing beat can stall; earlier lanes fill under backpressure.
    assign i_ready_o = !reset & (!w_final | !e_valid_o | e_ready_i);
    assign w_accept  = i_valid_i & i_ready_o;
    assign w_load    = w_accept & w_final;

    // Lanes above the fill point are still zero, so a short word is zero-padded.
    always_comb begin
        w_word = r_acc;
        for (int k = 0; k < BEATS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_word[k*DATA_W +: DATA_W] = i_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_final) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_word;
            end
        end
    end

    byte_packer_out_reg #(
`ifdef BYTE_PACKER_FLUSH_EN
        .LANES           (BEATS),
`endif
        .WORD_W          (WORD_W)
    ) u_out_reg (
        .clk             (clk),
        .reset           (reset),
        .i_load          (w_load),
        .i_load_data     (w_word),
`ifdef BYTE_PACKER_FLUSH_EN
        .i_load_keep     (w_keep),
        .o_keep          (e_keep_o),
`endif
        .i_handoff_ready (e_ready_i),
        .o_valid         (e_valid_o),
        .o_data          (e_data_o)
    );

endmodule : byte_packer
`default_nettype wire
